// File: rtl/ex_mem_pipe_reg_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ex_mem_pipe_reg_if : valid/ready bus carrying one EX/MEM pipeline entry
// Revision: 1.0
// ---------------------------------------------------------------------------
interface ex_mem_pipe_reg_if #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
);
   logic              Valid;
   logic              Ready;
   logic              WBrw;
   logic              WBmtoreg;
   logic              Branch;
   logic              MemRead;
   logic              MemWrite;
   logic [DATA_W-1:0] addResult;
   logic              zero;
   logic [DATA_W-1:0] ALUResult;
   logic [DATA_W-1:0] readData2;
   logic [REG_W-1:0]  ExtoMemWB;

   modport master (
      output Valid, WBrw, WBmtoreg, Branch, MemRead, MemWrite,
             addResult, zero, ALUResult, readData2, ExtoMemWB,
      input  Ready
   );

   modport slave (
      input  Valid, WBrw, WBmtoreg, Branch, MemRead, MemWrite,
             addResult, zero, ALUResult, readData2, ExtoMemWB,
      output Ready
   );
endinterface
`default_nettype wire

// File: rtl/ex_mem_pipe_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ex_mem_pipe_reg : EX/MEM pipeline register, optional skid, flush, stall count
// Revision: 1.0
// ---------------------------------------------------------------------------
module ex_mem_pipe_reg #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  wire logic             Clk,
   input  wire logic             Rst,
   input  wire logic             Flush,
   ex_mem_pipe_reg_if.slave      ex_side,
   ex_mem_pipe_reg_if.master     mem_side,
   output logic                  OutPCSrc,
   output logic [CNT_W-1:0]      StallCnt
);

   typedef struct packed {
      logic              wb_rw;
      logic              wb_mtoreg;
      logic              branch;
      logic              mem_read;
      logic              mem_write;
      logic [DATA_W-1:0] add_result;
      logic              zero;
      logic [DATA_W-1:0] alu_result;
      logic [DATA_W-1:0] read_data2;
      logic [REG_W-1:0]  dest;
   } entry_t;

   localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

   entry_t           w_in_entry;
   entry_t           r_main;
   logic             w_out_valid;
   logic             w_in_ready;
   logic             w_accept;
   logic             w_emit;
   logic [CNT_W-1:0] r_stall_cnt;

   assign w_in_entry = '{
      wb_rw:      ex_side.WBrw,
      wb_mtoreg:  ex_side.WBmtoreg,
      branch:     ex_side.Branch,
      mem_read:   ex_side.MemRead,
      mem_write:  ex_side.MemWrite,
      add_result: ex_side.addResult,
      zero:       ex_side.zero,
      alu_result: ex_side.ALUResult,
      read_data2: ex_side.readData2,
      dest:       ex_side.ExtoMemWB
   };

   assign w_accept = ex_side.Valid & w_in_ready;
   assign w_emit   = w_out_valid & mem_side.Ready;

   generate
      if (SKID != 0) begin : g_skid
         typedef enum logic [1:0] {
            ST_EMPTY = 2'd0,
            ST_ONE   = 2'd1,
            ST_FULL  = 2'd2
         } state_t;

         state_t r_state;
         state_t w_state_nxt;
         entry_t r_skid;
         logic   w_load_main_in;
         logic   w_load_main_skid;
         logic   w_load_skid;

         always_ff @(posedge Clk) begin
            if (Rst) begin
               r_state <= ST_EMPTY;
            end else begin
               r_state <= w_state_nxt;
            end
         end

         always_comb begin
            w_state_nxt      = r_state;
            w_load_main_in   = 1'b0;
            w_load_main_skid = 1'b0;
            w_load_skid      = 1'b0;
            if (Flush) begin
               w_state_nxt = ST_EMPTY;
            end else begin
               case (r_state)
                  ST_EMPTY: begin
                     if (w_accept) begin
                        w_state_nxt    = ST_ONE;
                        w_load_main_in = 1'b1;
                     end
                  end
                  ST_ONE: begin
                     if (w_accept && w_emit) begin
                        w_load_main_in = 1'b1;
                     end else if (w_accept) begin
                        w_state_nxt = ST_FULL;
                        w_load_skid = 1'b1;
                     end else if (w_emit) begin
                        w_state_nxt = ST_EMPTY;
                     end
                  end
                  ST_FULL: begin
                     // Skid entry is older than anything upstream, so it moves up first.
                     if (w_emit) begin
                        w_state_nxt      = ST_ONE;
                        w_load_main_skid = 1'b1;
                     end
                  end
                  default: w_state_nxt = ST_EMPTY;
               endcase
            end
         end

         always_ff @(posedge Clk) begin
            if (Rst) begin
               r_main <= '0;
               r_skid <= '0;
            end else begin
               if (w_load_main_in) begin
                  r_main <= w_in_entry;
               end else if (w_load_main_skid) begin
                  r_main <= r_skid;
               end
               if (w_load_skid) begin
                  r_skid <= w_in_entry;
               end
            end
         end

         assign w_out_valid = (r_state != ST_EMPTY);
         assign w_in_ready  = !Rst && (r_state != ST_FULL);
      end else begin : g_flat
         logic r_valid;

         always_ff @(posedge Clk) begin
            if (Rst) begin
               r_valid <= 1'b0;
               r_main  <= '0;
            end else if (Flush) begin
               r_valid <= 1'b0;
            end else if (w_accept) begin
               r_valid <= 1'b1;
               r_main  <= w_in_entry;
            end else if (w_emit) begin
               r_valid <= 1'b0;
            end
         end

         assign w_out_valid = r_valid;
         assign w_in_ready  = !Rst && (!r_valid || mem_side.Ready);
      end
   endgenerate

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_stall_cnt <= '0;
      end else if (w_out_valid && !mem_side.Ready && !Flush && (r_stall_cnt != c_CNT_MAX)) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   assign ex_side.Ready      = w_in_ready;
   assign mem_side.Valid     = w_out_valid;
   // Control bits are gated so an empty stage looks like a bubble downstream.
   assign mem_side.WBrw      = w_out_valid & r_main.wb_rw;
   assign mem_side.WBmtoreg  = w_out_valid & r_main.wb_mtoreg;
   assign mem_side.Branch    = w_out_valid & r_main.branch;
   assign mem_side.MemRead   = w_out_valid & r_main.mem_read;
   assign mem_side.MemWrite  = w_out_valid & r_main.mem_write;
   assign mem_side.addResult = r_main.add_result;
   assign mem_side.zero      = r_main.zero;
   assign mem_side.ALUResult = r_main.alu_result;
   assign mem_side.readData2 = r_main.read_data2;
   assign mem_side.ExtoMemWB = r_main.dest;
   assign OutPCSrc           = w_out_valid & r_main.branch & r_main.zero;
   assign StallCnt           = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_pipe_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ex_mem_pipe_reg : random stimulus vs. queue model, skid and flat variants
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_ex_mem_pipe_reg;

   localparam int c_DATA_W = 32;
   localparam int c_REG_W  = 5;
   localparam int c_CNT_W  = 4;
   localparam int c_CYCLES = 800;

   typedef struct packed {
      logic        wb_rw;
      logic        wb_mtoreg;
      logic        branch;
      logic        mem_read;
      logic        mem_write;
      logic [31:0] add_result;
      logic        zero;
      logic [31:0] alu_result;
      logic [31:0] read_data2;
      logic [4:0]  dest;
   } ent_t;

   logic clk = 1'b0;
   logic rst;
   logic flush;
   logic ivalid;
   logic ordy;
   ent_t cur;

   logic [c_CNT_W-1:0] stall_s1;
   logic [c_CNT_W-1:0] stall_s0;
   logic               pcsrc_s1;
   logic               pcsrc_s0;

   int n_vec    = 0;
   int n_miscmp = 0;

   // Model: index 1 = skid variant (holds two), index 0 = flat variant (holds one).
   ent_t fifo [2][2];
   int   fill [2];
   ent_t last [2];
   int   scnt [2];

   ex_mem_pipe_reg_if #(.DATA_W(c_DATA_W), .REG_W(c_REG_W)) ex_s1 ();
   ex_mem_pipe_reg_if #(.DATA_W(c_DATA_W), .REG_W(c_REG_W)) mem_s1 ();
   ex_mem_pipe_reg_if #(.DATA_W(c_DATA_W), .REG_W(c_REG_W)) ex_s0 ();
   ex_mem_pipe_reg_if #(.DATA_W(c_DATA_W), .REG_W(c_REG_W)) mem_s0 ();

   ex_mem_pipe_reg #(.DATA_W(c_DATA_W), .REG_W(c_REG_W), .SKID(1), .CNT_W(c_CNT_W)) u_dut_skid (
      .Clk      (clk),
      .Rst      (rst),
      .Flush    (flush),
      .ex_side  (ex_s1),
      .mem_side (mem_s1),
      .OutPCSrc (pcsrc_s1),
      .StallCnt (stall_s1)
   );

   ex_mem_pipe_reg #(.DATA_W(c_DATA_W), .REG_W(c_REG_W), .SKID(0), .CNT_W(c_CNT_W)) u_dut_flat (
      .Clk      (clk),
      .Rst      (rst),
      .Flush    (flush),
      .ex_side  (ex_s0),
      .mem_side (mem_s0),
      .OutPCSrc (pcsrc_s0),
      .StallCnt (stall_s0)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miscmp++;
         $display("FAIL %s @%0t: got=%0h expected=%0h", tag, $time, got, exp);
      end
   endtask

   function automatic ent_t rand_ent();
      ent_t e;
      e.wb_rw      = 1'($urandom);
      e.wb_mtoreg  = 1'($urandom);
      e.branch     = 1'($urandom);
      e.mem_read   = 1'($urandom);
      e.mem_write  = 1'($urandom);
      e.add_result = $urandom;
      e.zero       = 1'($urandom);
      e.alu_result = $urandom;
      e.read_data2 = $urandom;
      e.dest       = 5'($urandom);
      return e;
   endfunction

   function automatic logic exp_ready(input int m);
      if (rst) return 1'b0;
      if (m == 1) return fill[m] < 2;
      return (fill[m] == 0) || ordy;
   endfunction

   task automatic drive_ex();
      ex_s1.Valid     = ivalid;          ex_s0.Valid     = ivalid;
      ex_s1.WBrw      = cur.wb_rw;       ex_s0.WBrw      = cur.wb_rw;
      ex_s1.WBmtoreg  = cur.wb_mtoreg;   ex_s0.WBmtoreg  = cur.wb_mtoreg;
      ex_s1.Branch    = cur.branch;      ex_s0.Branch    = cur.branch;
      ex_s1.MemRead   = cur.mem_read;    ex_s0.MemRead   = cur.mem_read;
      ex_s1.MemWrite  = cur.mem_write;   ex_s0.MemWrite  = cur.mem_write;
      ex_s1.addResult = cur.add_result;  ex_s0.addResult = cur.add_result;
      ex_s1.zero      = cur.zero;        ex_s0.zero      = cur.zero;
      ex_s1.ALUResult = cur.alu_result;  ex_s0.ALUResult = cur.alu_result;
      ex_s1.readData2 = cur.read_data2;  ex_s0.readData2 = cur.read_data2;
      ex_s1.ExtoMemWB = cur.dest;        ex_s0.ExtoMemWB = cur.dest;
      mem_s1.Ready    = ordy;            mem_s0.Ready    = ordy;
   endtask

   task automatic chk_dut(input string nm, input int m, input logic valid, input logic ready,
                          input logic [4:0] ctrl, input logic [101:0] data, input logic pcsrc,
                          input logic [3:0] cnt);
      ent_t em;
      logic ev;
      ev = fill[m] > 0;
      em = ev ? fifo[m][0] : last[m];
      chk({nm, ".OutValid"}, 128'(valid), 128'(ev));
      chk({nm, ".InReady"},  128'(ready), 128'(exp_ready(m)));
      chk({nm, ".ctrl"},     128'(ctrl),
          ev ? 128'({em.wb_rw, em.wb_mtoreg, em.branch, em.mem_read, em.mem_write}) : 128'(0));
      chk({nm, ".data"},     128'(data),
          128'({em.add_result, em.zero, em.alu_result, em.read_data2, em.dest}));
      chk({nm, ".PCSrc"},    128'(pcsrc), 128'(ev & em.branch & em.zero));
      chk({nm, ".StallCnt"}, 128'(cnt), 128'(scnt[m]));
   endtask

   task automatic model_step();
      for (int m = 0; m < 2; m++) begin
         logic rdy;
         logic acc;
         logic emit;
         rdy  = exp_ready(m);
         acc  = ivalid && rdy;
         emit = (fill[m] > 0) && ordy;
         if (rst) begin
            fill[m] = 0;
            last[m] = '0;
            scnt[m] = 0;
         end else begin
            if ((fill[m] > 0) && !ordy && !flush && (scnt[m] < 15)) scnt[m]++;
            if (flush) begin
               fill[m] = 0;
            end else begin
               if (emit) begin
                  fifo[m][0] = fifo[m][1];
                  fill[m]--;
               end
               if (acc) begin
                  fifo[m][fill[m]] = cur;
                  fill[m]++;
               end
            end
            if (fill[m] > 0) last[m] = fifo[m][0];
         end
      end
   endtask

   initial begin
      for (int m = 0; m < 2; m++) begin
         fill[m] = 0;
         last[m] = '0;
         scnt[m] = 0;
      end
      rst    = 1'b1;
      flush  = 1'b0;
      ivalid = 1'b1;
      ordy   = 1'b0;
      cur    = rand_ent();
      drive_ex();

      for (int c = 0; c < c_CYCLES; c++) begin
         @(negedge clk);
         cur = rand_ent();
         if (c < 2) begin
            rst = 1'b1; flush = 1'b0; ivalid = 1'b1; ordy = 1'(($urandom_range(1, 0)));
         end else if (c >= 300 && c < 330) begin
            // Long stall so the counter reaches and sits at saturation.
            rst = 1'b0; flush = 1'b0; ivalid = 1'(($urandom_range(1, 0))); ordy = 1'b0;
         end else if (c >= 330 && c < 360) begin
            rst = 1'b0; flush = 1'b0; ivalid = 1'b1; ordy = 1'b1;
         end else begin
            rst    = ($urandom_range(249, 0) == 0);
            flush  = ($urandom_range(24, 0) == 0);
            ivalid = ($urandom_range(3, 0) != 0);
            ordy   = ($urandom_range(4, 0) < 3);
         end
         drive_ex();
         #1;
         chk_dut("skid", 1, mem_s1.Valid, ex_s1.Ready,
                 {mem_s1.WBrw, mem_s1.WBmtoreg, mem_s1.Branch, mem_s1.MemRead, mem_s1.MemWrite},
                 {mem_s1.addResult, mem_s1.zero, mem_s1.ALUResult, mem_s1.readData2, mem_s1.ExtoMemWB},
                 pcsrc_s1, stall_s1);
         chk_dut("flat", 0, mem_s0.Valid, ex_s0.Ready,
                 {mem_s0.WBrw, mem_s0.WBmtoreg, mem_s0.Branch, mem_s0.MemRead, mem_s0.MemWrite},
                 {mem_s0.addResult, mem_s0.zero, mem_s0.ALUResult, mem_s0.readData2, mem_s0.ExtoMemWB},
                 pcsrc_s0, stall_s0);
         @(posedge clk);
         model_step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end

endmodule
`default_nettype wire
